// File: rtl/note_scheduler_pkg.sv
// Shared sizes, chart entry layout and scheduler state codes for the
// falling-note playfield.
package note_scheduler_pkg;

    localparam int LANES    = 8;
    localparam int SLOTS    = 16;
    localparam int SLOT_AW  = $clog2(SLOTS);
    localparam int LANE_W   = $clog2(LANES);
    localparam int CHART_AW = 8;
    localparam int Y_W      = 10;
    localparam int SCORE_W  = 16;

    // ROM word: [15:8] frames to wait, [7:0] lanes to spawn; all-zero word ends the chart.
    typedef struct packed {
        logic [7:0]       delta;
        logic [LANES-1:0] mask;
    } chart_entry_t;

    typedef logic [2:0] sched_state_t;
    localparam sched_state_t ST_IDLE       = 3'd0;
    localparam sched_state_t ST_FETCH      = 3'd1;
    localparam sched_state_t ST_WAIT_ROM   = 3'd2;
    localparam sched_state_t ST_WAIT_FRAME = 3'd3;
    localparam sched_state_t ST_SWEEP      = 3'd4;
    localparam sched_state_t ST_SPAWN      = 3'd5;
    localparam sched_state_t ST_DONE       = 3'd6;

    function automatic logic [LANE_W-1:0] lowest_lane(input logic [LANES-1:0] mask);
        lowest_lane = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (mask[i]) lowest_lane = LANE_W'(i);
        end
    endfunction

endpackage

// File: rtl/note_scheduler_if.sv
// Chart ROM port and renderer slot-read port of the note scheduler.
// master = scheduler side, slave = ROM / renderer side.
interface note_scheduler_if;
    import note_scheduler_pkg::*;

    logic [CHART_AW-1:0] chart_addr;
    logic [15:0]         chart_data;
    logic [SLOT_AW-1:0]  slot_idx;
    logic                slot_valid;
    logic [LANE_W-1:0]   slot_lane;
    logic [Y_W-1:0]      slot_y;

    modport master (
        output chart_addr,
        input  chart_data,
        input  slot_idx,
        output slot_valid, slot_lane, slot_y
    );

    modport slave (
        input  chart_addr,
        output chart_data,
        output slot_idx,
        input  slot_valid, slot_lane, slot_y
    );

endinterface

// File: rtl/note_scheduler_slot_alloc.sv
// Picks the lowest-numbered free slot in the live-note table.
module slot_alloc
    import note_scheduler_pkg::*;
(
    input  logic [SLOTS-1:0]   valid,
    output logic [SLOT_AW-1:0] free_idx,
    output logic               any_free
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path can infer a latch.
        free_idx = '0;
        any_free = 1'b0;
        for (int i = SLOTS - 1; i >= 0; i--) begin
            if (!valid[i]) begin
                free_idx = SLOT_AW'(i);
                any_free = 1'b1;
            end
        end
    end

endmodule

// File: rtl/note_scheduler.sv
// Chart-driven note spawner, per-frame note mover and strike-line judge
// for the falling-note playfield.
module note_scheduler
    import note_scheduler_pkg::*;
#(
    parameter int STRIKE_Y = 420,
    parameter int HIT_WIN  = 16,
    parameter int SPEED    = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               frame_clk,
    input  logic               start,
    input  logic [LANES-1:0]   keys,
    note_scheduler_if.master   bus,
    output logic [LANES-1:0]   keyTrack,
    output logic [LANES-1:0]   hit_pulse,
    output logic [LANES-1:0]   miss_pulse,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    output logic               overflow
);

    localparam logic [Y_W:0] WIN_LO = (Y_W + 1)'(STRIKE_Y - HIT_WIN);
    localparam logic [Y_W:0] WIN_HI = (Y_W + 1)'(STRIKE_Y + HIT_WIN);

    sched_state_t       state;
    logic [SLOTS-1:0]   slot_v;
    logic [LANE_W-1:0]  slot_l  [SLOTS];
    logic [Y_W-1:0]     slot_yv [SLOTS];

    logic               frame_q;
    logic               frame_pend;
    logic               in_frame;
    logic [7:0]         countdown;
    logic [LANES-1:0]   spawn_mask;
    logic [LANES-1:0]   press;
    logic [SLOT_AW-1:0] sweep_idx;

    logic               frame_edge;
    logic               consume;
    chart_entry_t       entry;
    logic [SLOT_AW-1:0] free_idx;
    logic               any_free;
    logic [LANE_W-1:0]  spawn_lane;
    logic [LANE_W-1:0]  cur_lane;
    logic [Y_W:0]       y_next;
    logic               cur_hit;
    logic               cur_miss;

    slot_alloc u_alloc (
        .valid    (slot_v),
        .free_idx (free_idx),
        .any_free (any_free)
    );

    assign bus.slot_valid = slot_v[bus.slot_idx];
    assign bus.slot_lane  = slot_l[bus.slot_idx];
    assign bus.slot_y     = slot_yv[bus.slot_idx];

    assign entry      = bus.chart_data;
    assign frame_edge = frame_clk & ~frame_q;
    // A start pulse in IDLE/DONE leaves a pending frame for the new chart to use.
    assign consume    = frame_pend &&
                        ((state == ST_WAIT_FRAME) ||
                         ((state == ST_IDLE || state == ST_DONE) && !start));

    assign spawn_lane = lowest_lane(spawn_mask);
    assign cur_lane   = slot_l[sweep_idx];
    assign y_next     = {1'b0, slot_yv[sweep_idx]} + (Y_W + 1)'(SPEED);
    assign cur_hit    = slot_v[sweep_idx] && press[cur_lane] &&
                        (y_next >= WIN_LO) && (y_next <= WIN_HI);
    assign cur_miss   = slot_v[sweep_idx] && !cur_hit && (y_next > WIN_HI);

    // NOTE: non-blocking throughout, so every read here sees pre-edge values
    // (e.g. press is formed from the previous keyTrack).
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= ST_IDLE;
            slot_v         <= '0;
            // NOTE: lane/Y payload is reset too; the table is plain flops and must come up clean.
            for (int i = 0; i < SLOTS; i++) begin
                slot_l[i]  <= '0;
                slot_yv[i] <= '0;
            end
            bus.chart_addr <= '0;
            frame_q        <= 1'b0;
            frame_pend     <= 1'b0;
            in_frame       <= 1'b0;
            countdown      <= '0;
            spawn_mask     <= '0;
            press          <= '0;
            sweep_idx      <= '0;
            keyTrack       <= '0;
            hit_pulse      <= '0;
            miss_pulse     <= '0;
            score          <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            hit_pulse  <= '0;
            miss_pulse <= '0;
            frame_q    <= frame_clk;
            frame_pend <= (frame_pend & ~consume) | frame_edge;

            if (consume) begin
                keyTrack  <= keys;
                press     <= keys & ~keyTrack;
                sweep_idx <= '0;
            end

            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        slot_v         <= '0;
                        score          <= '0;
                        done           <= 1'b0;
                        overflow       <= 1'b0;
                        busy           <= 1'b1;
                        in_frame       <= 1'b0;
                        bus.chart_addr <= '0;
                        state          <= ST_FETCH;
                    end else if (consume && state == ST_DONE) begin
                        state <= ST_SWEEP;
                    end
                end

                ST_FETCH: state <= ST_WAIT_ROM;

                ST_WAIT_ROM: begin
                    if (entry == '0) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= ST_DONE;
                    end else begin
                        countdown      <= entry.delta;
                        spawn_mask     <= entry.mask;
                        bus.chart_addr <= bus.chart_addr + CHART_AW'(1);
                        // Zero-delay entries fetched while spawning join the current frame.
                        if (in_frame && entry.delta == 8'd0) begin
                            state <= ST_SPAWN;
                        end else begin
                            in_frame <= 1'b0;
                            state    <= ST_WAIT_FRAME;
                        end
                    end
                end

                ST_WAIT_FRAME: if (consume) state <= ST_SWEEP;

                ST_SWEEP: begin
                    if (cur_hit) begin
                        slot_v[sweep_idx]   <= 1'b0;
                        hit_pulse[cur_lane] <= 1'b1;
                        press[cur_lane]     <= 1'b0;
                        if (score != '1) score <= score + SCORE_W'(1);
                    end else if (cur_miss) begin
                        slot_v[sweep_idx]    <= 1'b0;
                        miss_pulse[cur_lane] <= 1'b1;
                    end else if (slot_v[sweep_idx]) begin
                        slot_yv[sweep_idx] <= y_next[Y_W-1:0];
                    end

                    sweep_idx <= sweep_idx + SLOT_AW'(1);
                    if (sweep_idx == SLOT_AW'(SLOTS - 1)) begin
                        if (done) begin
                            state <= ST_DONE;
                        end else if (countdown != 8'd0) begin
                            countdown <= countdown - 8'd1;
                            state     <= ST_WAIT_FRAME;
                        end else begin
                            in_frame <= 1'b1;
                            state    <= ST_SPAWN;
                        end
                    end
                end

                ST_SPAWN: begin
                    if (spawn_mask == '0) begin
                        state <= ST_FETCH;
                    end else begin
                        if (any_free) begin
                            slot_v[free_idx]  <= 1'b1;
                            slot_l[free_idx]  <= spawn_lane;
                            slot_yv[free_idx] <= '0;
                        end else begin
                            overflow <= 1'b1;
                        end
                        spawn_mask[spawn_lane] <= 1'b0;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_scheduler.sv
// Directed bench for note_scheduler: expected hit/miss pulses go into a
// scoreboard queue that a negedge monitor drains; table state is peeked directly.
module tb_note_scheduler;
    import note_scheduler_pkg::*;

    localparam int FRAME_GAP = 48;

    typedef struct packed {
        logic [7:0]  hit;
        logic [7:0]  miss;
        logic [15:0] score;
    } exp_t;

    logic             Clk       = 1'b0;
    logic             Reset     = 1'b1;
    logic             frame_clk = 1'b0;
    logic             start     = 1'b0;
    logic [LANES-1:0] keys      = '0;
    logic [LANES-1:0] keyTrack;
    logic [LANES-1:0] hit_pulse;
    logic [LANES-1:0] miss_pulse;
    logic [15:0]      score;
    logic             busy;
    logic             done;
    logic             overflow;

    logic [15:0] rom [256];
    exp_t        exp_q [$];
    exp_t        mon_e;
    int          tests = 0;
    int          fails = 0;

    note_scheduler_if bus();

    note_scheduler dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .frame_clk  (frame_clk),
        .start      (start),
        .keys       (keys),
        .bus        (bus),
        .keyTrack   (keyTrack),
        .hit_pulse  (hit_pulse),
        .miss_pulse (miss_pulse),
        .score      (score),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow)
    );

    always #5 Clk = ~Clk;

    always_ff @(posedge Clk) bus.chart_data <= rom[bus.chart_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    always @(negedge Clk) begin
        if (!Reset && (hit_pulse != '0 || miss_pulse != '0)) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got hit=%h miss=%h, required no pulse",
                         hit_pulse, miss_pulse);
            end else begin
                mon_e = exp_q.pop_front();
                check("pulse_hit",   32'(hit_pulse),  32'(mon_e.hit));
                check("pulse_miss",  32'(miss_pulse), 32'(mon_e.miss));
                check("pulse_score", 32'(score),      32'(mon_e.score));
            end
        end
    end

    task automatic peek(input int idx, output logic v, output logic [LANE_W-1:0] l,
                        output logic [Y_W-1:0] y);
        bus.slot_idx = SLOT_AW'(idx);
        #1;
        v = bus.slot_valid;
        l = bus.slot_lane;
        y = bus.slot_y;
    endtask

    task automatic count_valid(output int n);
        logic v;
        logic [LANE_W-1:0] l;
        logic [Y_W-1:0] y;
        n = 0;
        for (int i = 0; i < SLOTS; i++) begin
            peek(i, v, l, y);
            if (v) n++;
        end
    endtask

    task automatic frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (FRAME_GAP) @(negedge Clk);
    endtask

    task automatic start_chart();
        @(negedge Clk) start = 1'b1;
        @(negedge Clk) start = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic check_cleared(input string tag);
        int n;
        check({tag, "_chart_addr"}, 32'(bus.chart_addr), 32'h0);
        check({tag, "_keytrack"},   32'(keyTrack),       32'h0);
        check({tag, "_hit"},        32'(hit_pulse),      32'h0);
        check({tag, "_miss"},       32'(miss_pulse),     32'h0);
        check({tag, "_score"},      32'(score),          32'h0);
        check({tag, "_busy"},       32'(busy),           32'h0);
        check({tag, "_done"},       32'(done),           32'h0);
        check({tag, "_overflow"},   32'(overflow),       32'h0);
        count_valid(n);
        check({tag, "_live_slots"}, 32'(n), 32'h0);
    endtask

    initial begin
        logic v;
        logic [LANE_W-1:0] l;
        logic [Y_W-1:0] y;
        int n;

        for (int i = 0; i < 256; i++) rom[i] = '0;
        bus.slot_idx = '0;

        repeat (2) @(negedge Clk);
        check_cleared("por");
        Reset = 1'b0;
        @(negedge Clk);

        // Five live notes, then reset in the middle of a sweep.
        rom[0] = 16'h001F;
        rom[1] = 16'h0000;
        start_chart();
        frame_tick();
        count_valid(n);
        check("five_live", 32'(n), 32'd5);
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        check_cleared("midsweep");
        Reset = 1'b0;
        @(negedge Clk);

        // Single lane-0 note reaches the strike line and is hit.
        rom[0] = 16'h0001;
        start_chart();
        check("busy_running", 32'(busy), 32'h1);
        frame_tick();
        peek(0, v, l, y);
        check("spawn_valid", 32'(v), 32'h1);
        check("spawn_lane",  32'(l), 32'h0);
        check("spawn_y",     32'(y), 32'h0);
        check("end_done",    32'(done), 32'h1);
        check("end_busy",    32'(busy), 32'h0);
        check("end_addr",    32'(bus.chart_addr), 32'h1);
        repeat (104) frame_tick();
        peek(0, v, l, y);
        check("pre_hit_valid", 32'(v), 32'h1);
        check("pre_hit_y",     32'(y), 32'd416);
        keys = 8'h01;
        exp_q.push_back('{hit: 8'h01, miss: 8'h00, score: 16'd1});
        frame_tick();
        peek(0, v, l, y);
        check("hit_invalidates", 32'(v), 32'h0);
        check("hit_score",       32'(score), 32'd1);
        check("keytrack_held",   32'(keyTrack), 32'h01);
        keys = 8'h00;
        frame_tick();

        // Same chart, no key: window edge at 436 survives, 440 misses.
        exp_q.push_back('{hit: 8'h00, miss: 8'h01, score: 16'd0});
        start_chart();
        check("restart_score", 32'(score), 32'h0);
        check("restart_done",  32'(done),  32'h0);
        frame_tick();
        repeat (109) frame_tick();
        peek(0, v, l, y);
        check("edge_valid", 32'(v), 32'h1);
        check("edge_y",     32'(y), 32'd436);
        frame_tick();
        peek(0, v, l, y);
        check("miss_invalidates", 32'(v), 32'h0);
        check("miss_score",       32'(score), 32'h0);

        // Two lane-2 notes in the window, one press; key then held.
        rom[0] = 16'h0004;
        rom[1] = 16'h0004;
        rom[2] = 16'h0000;
        start_chart();
        frame_tick();
        count_valid(n);
        check("pair_live", 32'(n), 32'd2);
        repeat (104) frame_tick();
        keys = 8'h04;
        exp_q.push_back('{hit: 8'h04, miss: 8'h00, score: 16'd1});
        exp_q.push_back('{hit: 8'h00, miss: 8'h04, score: 16'd1});
        frame_tick();
        peek(0, v, l, y);
        check("pair_low_hit", 32'(v), 32'h0);
        peek(1, v, l, y);
        check("pair_high_valid", 32'(v), 32'h1);
        check("pair_high_y",     32'(y), 32'd420);
        check("pair_keytrack",   32'(keyTrack), 32'h04);
        repeat (4) frame_tick();
        peek(1, v, l, y);
        check("held_no_rehit", 32'(v), 32'h1);
        check("held_y",        32'(y), 32'd436);
        frame_tick();
        peek(1, v, l, y);
        check("held_missed", 32'(v), 32'h0);
        check("held_score",  32'(score), 32'd1);
        keys = 8'h00;
        frame_tick();

        // Two extra frame edges during a sweep: only one is queued.
        rom[0] = 16'h0001;
        rom[1] = 16'h0000;
        start_chart();
        frame_tick();
        @(negedge Clk) frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame_clk = 1'b1;
        @(negedge Clk) frame_clk = 1'b0;
        repeat (FRAME_GAP) @(negedge Clk);
        peek(0, v, l, y);
        check("queued_edge_y", 32'(y), 32'd8);

        // Three full-mask entries overflow the 16-slot table.
        rom[0] = 16'h00FF;
        rom[1] = 16'h00FF;
        rom[2] = 16'h00FF;
        rom[3] = 16'h0000;
        start_chart();
        check("ovf_clear_at_start", 32'(overflow), 32'h0);
        frame_tick();
        count_valid(n);
        check("ovf_live", 32'(n), 32'd16);
        check("ovf_flag", 32'(overflow), 32'h1);
        peek(8, v, l, y);
        check("ovf_slot8_lane", 32'(l), 32'd0);
        peek(15, v, l, y);
        check("ovf_slot15_lane", 32'(l), 32'd7);
        check("ovf_addr", 32'(bus.chart_addr), 32'd3);
        start_chart();
        check("ovf_sticky_cleared", 32'(overflow), 32'h0);
        count_valid(n);
        check("restart_table_clear", 32'(n), 32'd0);

        repeat (10) @(negedge Clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
